// File: rtl/dlt_seq_ctrl.sv
// Drives SR, G and D onto a bank of CC_DLT latches in a fixed phase order,
// samples the bank after each phase and reports pass/fail plus a per-bit error mask.
//
// state       | meaning
// ------------+-----------------------------------------------
// IDLE        | waiting for start; outputs inactive
// SR_ON       | logical sr active for SR_CYCLES
// SR_SETTLE   | sr released, settle for SETTLE_CYCLES
// SAMPLE_SR   | fold q ^ exp_sr into err_mask
// GATE_ON     | logical g active, d driven, for GATE_CYCLES
// GATE_HOLD   | g released, d held, for SETTLE_CYCLES
// SAMPLE_GATE | fold q ^ exp_gate into err_mask, resolve pass
// DONE        | one-cycle done pulse
module dlt_seq_ctrl #(
  parameter int WIDTH         = 32,
  parameter int SR_CYCLES     = 2,
  parameter int GATE_CYCLES   = 2,
  parameter int SETTLE_CYCLES = 1,
  parameter int G_INV         = 0,
  parameter int SR_INV        = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             d_val,
  input  logic [WIDTH-1:0] exp_sr,
  input  logic [WIDTH-1:0] exp_gate,
  input  logic [WIDTH-1:0] q,
  output logic             d,
  output logic             g,
  output logic             sr,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [WIDTH-1:0] err_mask
);

  typedef enum logic [2:0] {
    IDLE,
    SR_ON,
    SR_SETTLE,
    SAMPLE_SR,
    GATE_ON,
    GATE_HOLD,
    SAMPLE_GATE,
    DONE
  } state_t;

  localparam int MAX_AB  = (SR_CYCLES > GATE_CYCLES) ? SR_CYCLES : GATE_CYCLES;
  localparam int MAX_CNT = (MAX_AB > SETTLE_CYCLES) ? MAX_AB : SETTLE_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CNT) + 1;

  // Counters load count-1 on state entry and the phase ends when they reach zero.
  localparam logic [CNT_W-1:0] SR_LOAD     = CNT_W'(SR_CYCLES - 1);
  localparam logic [CNT_W-1:0] GATE_LOAD   = CNT_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  localparam logic G_OFF  = (G_INV != 0);
  localparam logic G_ACT  = ~G_OFF;
  localparam logic SR_OFF = (SR_INV != 0);
  localparam logic SR_ACT = ~SR_OFF;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             d_cap;
  logic [WIDTH-1:0] exp_sr_cap;
  logic [WIDTH-1:0] exp_gate_cap;
  logic [WIDTH-1:0] err_gate;

  assign err_gate = err_mask | (q ^ exp_gate_cap);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      d_cap        <= 1'b0;
      exp_sr_cap   <= '0;
      exp_gate_cap <= '0;
      d            <= 1'b0;
      g            <= G_OFF;
      sr           <= SR_OFF;
      busy         <= 1'b0;
      done         <= 1'b0;
      pass         <= 1'b0;
      err_mask     <= '0;
    end else begin
      done <= 1'b0;
      if (abort && busy && state != DONE) begin
        // err_mask deliberately keeps whatever was accumulated so far
        state <= IDLE;
        g     <= G_OFF;
        sr    <= SR_OFF;
        d     <= 1'b0;
        busy  <= 1'b0;
        pass  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              d_cap        <= d_val;
              exp_sr_cap   <= exp_sr;
              exp_gate_cap <= exp_gate;
              err_mask     <= '0;
              pass         <= 1'b0;
              busy         <= 1'b1;
              d            <= 1'b0;
              g            <= G_OFF;
              sr           <= SR_ACT;
              cnt          <= SR_LOAD;
              state        <= SR_ON;
            end
          end
          SR_ON: begin
            if (cnt == '0) begin
              sr    <= SR_OFF;
              cnt   <= SETTLE_LOAD;
              state <= SR_SETTLE;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          SR_SETTLE: begin
            if (cnt == '0) begin
              state <= SAMPLE_SR;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          SAMPLE_SR: begin
            err_mask <= err_mask | (q ^ exp_sr_cap);
            g        <= G_ACT;
            d        <= d_cap;
            cnt      <= GATE_LOAD;
            state    <= GATE_ON;
          end
          GATE_ON: begin
            if (cnt == '0) begin
              g     <= G_OFF;
              cnt   <= SETTLE_LOAD;
              state <= GATE_HOLD;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          GATE_HOLD: begin
            if (cnt == '0) begin
              state <= SAMPLE_GATE;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          SAMPLE_GATE: begin
            err_mask <= err_gate;
            pass     <= (err_gate == '0);
            done     <= 1'b1;
            state    <= DONE;
          end
          DONE: begin
            d     <= 1'b0;
            busy  <= 1'b0;
            state <= IDLE;
          end
          default: begin
            d     <= 1'b0;
            g     <= G_OFF;
            sr    <= SR_OFF;
            busy  <= 1'b0;
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dlt_seq_ctrl.sv
// Bench for dlt_seq_ctrl: two instances (default timing/polarity and an inverted,
// retimed variant), checked cycle by cycle against a phase-timeline model.
module tb_dlt_seq_ctrl;
  localparam int W = 32;
  localparam int S0 = 2, G0 = 2, E0 = 1;
  localparam int S1 = 3, G1 = 1, E1 = 2;

  logic clk = 1'b0;
  logic rst;
  logic sel;
  logic start_drv, abort_drv;
  logic start0, start1, abort0, abort1;
  logic d_val;
  logic [W-1:0] exp_sr, exp_gate, q;

  logic d0, g0, sr0, busy0, done0, pass0;
  logic d1, g1, sr1, busy1, done1, pass1;
  logic [W-1:0] err0, err1;

  logic o_d, o_g, o_sr, o_busy, o_done, o_pass;
  logic [W-1:0] o_err;

  int S, G, E;
  logic ginv, srinv;
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign start0 = start_drv & ~sel;
  assign start1 = start_drv & sel;
  assign abort0 = abort_drv & ~sel;
  assign abort1 = abort_drv & sel;

  always_comb begin
    o_d = sel ? d1 : d0;
    o_g = sel ? g1 : g0;
    o_sr = sel ? sr1 : sr0;
    o_busy = sel ? busy1 : busy0;
    o_done = sel ? done1 : done0;
    o_pass = sel ? pass1 : pass0;
    o_err = sel ? err1 : err0;
  end

  dlt_seq_ctrl #(.WIDTH(W), .SR_CYCLES(S0), .GATE_CYCLES(G0), .SETTLE_CYCLES(E0),
                 .G_INV(0), .SR_INV(0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .abort(abort0), .d_val(d_val),
    .exp_sr(exp_sr), .exp_gate(exp_gate), .q(q), .d(d0), .g(g0), .sr(sr0),
    .busy(busy0), .done(done0), .pass(pass0), .err_mask(err0));

  dlt_seq_ctrl #(.WIDTH(W), .SR_CYCLES(S1), .GATE_CYCLES(G1), .SETTLE_CYCLES(E1),
                 .G_INV(1), .SR_INV(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .abort(abort1), .d_val(d_val),
    .exp_sr(exp_sr), .exp_gate(exp_gate), .q(q), .d(d1), .g(g1), .sr(sr1),
    .busy(busy1), .done(done1), .pass(pass1), .err_mask(err1));

  task automatic set_dut(input logic s);
    sel = s;
    if (s) begin S = S1; G = G1; E = E1; ginv = 1'b1; srinv = 1'b1; end
    else   begin S = S0; G = G0; E = E0; ginv = 1'b0; srinv = 1'b0; end
  endtask

  // One run: start sampled at edge 0, then cycle t is the period after edge t-1.
  task automatic run(input logic dv, input logic [W-1:0] es, input logic [W-1:0] eg,
                     input logic [W-1:0] qs, input logic [W-1:0] qg,
                     input int abort_at, input int re_a, input int re_b, input int rst_at);
    int t_ssr, t_sg, t_done;
    logic [W-1:0] e_sr, e_tot, e_exp, e_abort;
    logic aborted, sr_l, g_l, busy_e, done_e, pass_e;
    t_ssr = S + E + 1;
    t_sg = t_ssr + G + E + 1;
    t_done = t_sg + 1;
    e_sr = qs ^ es;
    e_tot = e_sr | (qg ^ eg);
    e_abort = '0;
    aborted = 1'b0;
    @(negedge clk);
    start_drv = 1'b1;
    abort_drv = 1'($urandom_range(0, 1));
    d_val = dv; exp_sr = es; exp_gate = eg; q = $urandom;
    @(posedge clk); #1;
    for (int t = 1; t <= t_done + 2; t++) begin
      start_drv = (t == re_a) || (t == re_b);
      abort_drv = (t == abort_at);
      d_val = 1'($urandom); exp_sr = $urandom; exp_gate = $urandom;
      q = (t == t_ssr) ? qs : (t == t_sg) ? qg : $urandom;
      if (t == rst_at) begin
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({o_g, o_sr, o_d, o_busy, o_done, o_pass} !== {ginv, srinv, 4'b0000} || o_err !== '0) begin
          n_err++;
          $display("FAIL async_rst got g,sr,d,busy,done,pass=%b err=%h want %b err=0", {o_g, o_sr, o_d, o_busy, o_done, o_pass}, o_err, {ginv, srinv, 4'b0000});
        end
        @(negedge clk);
        rst = 1'b0; start_drv = 1'b0; abort_drv = 1'b0;
        return;
      end
      @(negedge clk);
      if (aborted) begin
        sr_l = 0; g_l = 0; busy_e = 0; done_e = 0; pass_e = 0; e_exp = e_abort;
      end else begin
        sr_l = (t <= S);
        g_l = (t > t_ssr) && (t <= t_ssr + G);
        busy_e = (t <= t_done);
        done_e = (t == t_done);
        pass_e = (t >= t_done) ? (e_tot == '0) : 1'b0;
        e_exp = (t <= t_ssr) ? '0 : (t <= t_sg) ? e_sr : e_tot;
      end
      n_cmp++;
      if (o_sr !== (sr_l ^ srinv)) begin n_err++; $display("FAIL sr t=%0d got %b want %b", t, o_sr, sr_l ^ srinv); end
      n_cmp++;
      if (o_g !== (g_l ^ ginv)) begin n_err++; $display("FAIL g t=%0d got %b want %b", t, o_g, g_l ^ ginv); end
      if (sr_l && g_l) begin n_err++; $display("FAIL overlap t=%0d model has sr and g both active", t); end
      n_cmp++;
      if (o_busy !== busy_e) begin n_err++; $display("FAIL busy t=%0d got %b want %b", t, o_busy, busy_e); end
      n_cmp++;
      if (o_done !== done_e) begin n_err++; $display("FAIL done t=%0d got %b want %b", t, o_done, done_e); end
      n_cmp++;
      if (o_pass !== pass_e) begin n_err++; $display("FAIL pass t=%0d got %b want %b", t, o_pass, pass_e); end
      n_cmp++;
      if (o_err !== e_exp) begin n_err++; $display("FAIL err_mask t=%0d got %h want %h", t, o_err, e_exp); end
      if (aborted || t <= t_ssr || t > t_done) begin
        n_cmp++;
        if (o_d !== 1'b0) begin n_err++; $display("FAIL d_idle t=%0d got %b want 0", t, o_d); end
      end else if (t < t_sg) begin
        n_cmp++;
        if (o_d !== dv) begin n_err++; $display("FAIL d_gate t=%0d got %b want %b", t, o_d, dv); end
      end
      if (!aborted && t == abort_at && t < t_done) begin
        aborted = 1'b1;
        e_abort = e_exp;
      end
      @(posedge clk); #1;
    end
    start_drv = 1'b0;
    abort_drv = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    n_cmp++;
    if ({g0, sr0, d0, busy0, done0, pass0} !== 6'b000000 || err0 !== '0) begin
      n_err++; $display("FAIL reset0 got %b err=%h want 000000 err=0", {g0, sr0, d0, busy0, done0, pass0}, err0);
    end
    n_cmp++;
    if ({g1, sr1, d1, busy1, done1, pass1} !== 6'b110000 || err1 !== '0) begin
      n_err++; $display("FAIL reset1 got %b err=%h want 110000 err=0", {g1, sr1, d1, busy1, done1, pass1}, err1);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_nominal();
    set_dut(1'b0);
    run(1'b1, '0, '1, '0, '1, 0, 0, 0, 0);
  endtask

  task automatic test_stuck_bit();
    set_dut(1'b0);
    run(1'b1, '0, '1, '0, 32'hFFFF_FFDF, 0, 0, 0, 0);
    n_cmp++;
    if (o_err !== 32'h0000_0020 || o_pass !== 1'b0) begin
      n_err++; $display("FAIL stuck_bit got err=%h pass=%b want err=00000020 pass=0", o_err, o_pass);
    end
  endtask

  task automatic test_restart_ignored();
    set_dut(1'b0);
    run(1'b1, '0, '1, '0, '1, 0, 3, S0 + G0 + 2 * E0 + 3, 0);
  endtask

  task automatic test_abort();
    set_dut(1'b0);
    run(1'b1, '0, '1, '0, '1, 5, 0, 0, 0);
  endtask

  task automatic test_inverted();
    set_dut(1'b1);
    run(1'b1, '0, '1, '0, '1, 0, 0, 0, 0);
    run(1'b0, '0, '0, 32'h0000_1000, '0, 0, 0, 0, 0);
  endtask

  task automatic test_async_reset();
    set_dut(1'b0);
    run(1'b1, '0, '1, '0, '1, 0, 0, 0, S0 + E0 + 2);
    run(1'b1, '0, '1, '0, '1, 0, 0, 0, 0);
  endtask

  task automatic test_random();
    int mode, t_done, ab, ra, rb, t_ssr, t_sg;
    logic dv;
    logic [W-1:0] es, eg, qs, qg;
    for (int i = 0; i < 40; i++) begin
      set_dut(1'(i % 2));
      t_ssr = S + E + 1;
      t_sg = t_ssr + G + E + 1;
      t_done = t_sg + 1;
      dv = 1'($urandom);
      es = $urandom;
      eg = $urandom;
      qs = ($urandom_range(0, 1) == 1) ? es : es ^ (32'h1 << $urandom_range(0, 31));
      qg = ($urandom_range(0, 1) == 1) ? eg : eg ^ $urandom;
      mode = $urandom_range(0, 2);
      ab = 0; ra = 0; rb = 0;
      if (mode == 1) begin
        ab = $urandom_range(1, t_done);
        if (ab == t_ssr || ab == t_sg) ab = ab - 1;
      end else if (mode == 2) begin
        ra = $urandom_range(1, t_done);
        rb = $urandom_range(1, t_done);
      end
      run(dv, es, eg, qs, qg, ab, ra, rb, 0);
    end
  endtask

  task automatic test_back_to_back();
    set_dut(1'b0);
    run(1'b0, 32'h0F0F_0F0F, 32'hAAAA_5555, 32'h0F0F_0F0F, 32'hAAAA_5555, 0, 0, 0, 0);
    run(1'b1, 32'h1234_5678, 32'h8765_4321, 32'h1234_5679, 32'h8765_4321, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b1;
    sel = 1'b0;
    start_drv = 1'b0; abort_drv = 1'b0;
    d_val = 1'b0; exp_sr = '0; exp_gate = '0; q = '0;
    set_dut(1'b0);
    @(negedge clk);
    test_reset();
    test_nominal();
    test_stuck_bit();
    test_restart_ignored();
    test_abort();
    test_inverted();
    test_async_reset();
    test_random();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired before the bench completed");
    $fatal(1, "watchdog");
  end
endmodule
